approx_mult_err_monitor: RTL and testbench

Downstream consumer of the unsigned 8x8 approximate multipliers. It takes each operand pair and the approximate product, recomputes the exact product, and accumulates error statistics over a programmed window of samples:
- error count
- sum of error distance
- maximum error distance
- count of over-estimates

It serves as the on-chip/bench characterisation stage that scores a multiplier variant under a stimulus stream.

---
 rtl/approx_mult_err_monitor.sv | 165 ++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an unsigned WIDTH x WIDTH approximate multiplier.
// Each accepted beat carries the operands and the multiplier's product. The
// block recomputes the exact product and accumulates error statistics over a
// window of num_samples beats.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start, in_ready low
// RUN   | accepting beats until the window count is exhausted
// DRAIN | window closed, last sample still in the pipeline
// DONE  | statistics final and held, start re-arms a new window
module approx_mult_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 17,
  parameter int ACC_W = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   over_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0] max_ed,
  output logic               sum_sat
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               s1_valid_q, s1_valid_d;
  logic [PW-1:0]      s1_exact_q, s1_exact_d;
  logic [PW-1:0]      s1_z_q, s1_z_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   over_cnt_q, over_cnt_d;
  logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
  logic [PW-1:0]      max_ed_q, max_ed_d;
  logic               sum_sat_q, sum_sat_d;

  logic               hs;
  logic               clear_stats;
  logic [PW-1:0]      ed;
  logic               gt;
  logic [ACC_W:0]     sum_wide;

  assign in_ready = (state_q == RUN);
  assign hs       = in_valid & in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign err_cnt  = err_cnt_q;
  assign over_cnt = over_cnt_q;
  assign sum_ed   = sum_ed_q;
  assign max_ed   = max_ed_q;
  assign sum_sat  = sum_sat_q;

  // Window sequencing: start handling, sample countdown and drain detection.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear_stats = 1'b1;
          if (num_samples != '0) begin
            remaining_d = num_samples;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (hs) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // S1 empties on this edge while S2 folds its sample into the
        // statistics, so DONE and the final statistics appear together.
        if (!s1_valid_d) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 captures the exact product and the approximate one on handshake.
  always_comb begin
    s1_valid_d = hs;
    s1_exact_d = s1_exact_q;
    s1_z_d     = s1_z_q;
    if (hs) begin
      s1_exact_d = PW'(x) * PW'(y);
      s1_z_d     = z;
    end
  end

  // Stage 2 scores the captured sample and updates the window statistics.
  always_comb begin
    gt         = (s1_z_q > s1_exact_q);
    ed         = gt ? (s1_z_q - s1_exact_q) : (s1_exact_q - s1_z_q);
    sum_wide   = {1'b0, sum_ed_q} + (ACC_W+1)'(ed);
    err_cnt_d  = err_cnt_q;
    over_cnt_d = over_cnt_q;
    sum_ed_d   = sum_ed_q;
    max_ed_d   = max_ed_q;
    sum_sat_d  = sum_sat_q;
    if (clear_stats) begin
      err_cnt_d  = '0;
      over_cnt_d = '0;
      sum_ed_d   = '0;
      max_ed_d   = '0;
      sum_sat_d  = 1'b0;
    end else if (s1_valid_q) begin
      if (ed != '0) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (gt) over_cnt_d = over_cnt_q + CNT_W'(1);
      if (ed > max_ed_q) max_ed_d = ed;
      if (sum_wide[ACC_W]) begin
        sum_ed_d  = '1;
        sum_sat_d = 1'b1;
      end else begin
        sum_ed_d = sum_wide[ACC_W-1:0];
      end
    end
  end

  // All state registers; reset discards any in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_z_q      <= '0;
      err_cnt_q   <= '0;
      over_cnt_q  <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      sum_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_z_q      <= s1_z_d;
      err_cnt_q   <= err_cnt_d;
      over_cnt_q  <= over_cnt_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      sum_sat_q   <= sum_sat_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: directed windows, expected statistics
// queued at start and compared by a monitor when done rises. A second
// instance with a 17-bit accumulator exercises saturation.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [16:0] num_samples;
  logic        in_valid;
  logic [7:0]  x, y;
  logic [15:0] z;

  logic        in_ready, busy, done, sum_sat;
  logic [16:0] err_cnt, over_cnt;
  logic [32:0] sum_ed;
  logic [15:0] max_ed;

  logic        s_in_ready, s_busy, s_done, s_sum_sat;
  logic [16:0] s_err_cnt, s_over_cnt, s_sum_ed;
  logic [15:0] s_max_ed;

  always #5 clk = ~clk;

  approx_mult_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .err_cnt(err_cnt), .over_cnt(over_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .sum_sat(sum_sat)
  );

  approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(17)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .x(x), .y(y), .z(z),
    .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .over_cnt(s_over_cnt),
    .sum_ed(s_sum_ed), .max_ed(s_max_ed), .sum_sat(s_sum_sat)
  );

  typedef struct {
    longint err, over, sum, mx, sat, sum17, sat17;
    int     beats, lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(longint err, longint over, longint sum, longint mx,
                              longint sat, longint sum17, longint sat17,
                              int beats, int lat);
    exp_t e;
    e.err = err; e.over = over; e.sum = sum; e.mx = mx; e.sat = sat;
    e.sum17 = sum17; e.sat17 = sat17; e.beats = beats; e.lat = lat;
    return e;
  endfunction

  // Monitor: compares statistics, beat count and done latency per window.
  initial begin
    exp_t e;
    bit   armed;
    int   hs_cnt, last_ev, cyc;
    armed = 0; hs_cnt = 0; last_ev = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        armed  = 0;
        hs_cnt = 0;
      end else begin
        if (armed && done) begin
          armed = 0;
          if (sb.size() == 0) begin
            check("done_without_window", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("err_cnt", err_cnt, e.err);
            check("over_cnt", over_cnt, e.over);
            check("sum_ed", sum_ed, e.sum);
            check("max_ed", max_ed, e.mx);
            check("sum_sat", sum_sat, e.sat);
            check("sum_ed_acc17", s_sum_ed, e.sum17);
            check("sum_sat_acc17", s_sum_sat, e.sat17);
            check("done_acc17", s_done, 1);
            check("beats_accepted", hs_cnt, e.beats);
            check("done_latency", cyc - last_ev, e.lat);
            check("busy_in_done", busy, 0);
          end
        end
        if (start && !busy) begin
          armed   = 1;
          hs_cnt  = 0;
          last_ev = cyc;
        end
        if (in_valid && in_ready) begin
          hs_cnt++;
          last_ev = cyc;
        end
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = 17'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int w;
    in_valid = 1'b1;
    x = a; y = b; z = p;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) check("done_timeout", sb.size(), 0);
  endtask

  logic [7:0]  ta, tb_v;
  logic [15:0] tp;
  bit          pat [7] = '{1, 0, 1, 1, 0, 1, 1};
  logic [7:0]  px  [7] = '{1, 99, 2, 3, 99, 4, 200};
  logic [15:0] pz  [7] = '{1, 0, 5, 9, 0, 15, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; x = '0; y = '0; z = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_over_cnt", over_cnt, 0);
    check("rst_sum_ed", sum_ed, 0);
    check("rst_max_ed", max_ed, 0);
    check("rst_sum_sat", sum_sat, 0);
    rst_n = 1'b1;

    // Exact products, 256 back-to-back beats.
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 256, 2));
    do_start(256);
    for (int i = 0; i < 256; i++) begin
      ta = 8'(i);
      tb_v = 8'(255 - i);
      tp = ta * tb_v;
      send(ta, tb_v, tp);
    end
    wait_done();

    // Worst single sample: exact 65025, reported 0.
    sb.push_back(mk(1, 0, 65025, 65025, 0, 65025, 0, 1, 2));
    do_start(1);
    send(8'd255, 8'd255, 16'd0);
    wait_done();

    // Mixed: ed 1 (over), ed 10 (under), ed 0.
    sb.push_back(mk(2, 1, 11, 10, 0, 11, 0, 3, 2));
    do_start(3);
    send(8'd3, 8'd5, 16'd16);
    send(8'd10, 8'd10, 16'd90);
    send(8'd7, 8'd0, 16'd0);
    wait_done();

    // Throttled window of 4; the 7th slot must be refused.
    sb.push_back(mk(2, 1, 2, 1, 0, 2, 0, 4, 2));
    do_start(4);
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      x = px[i]; y = px[i]; z = pz[i];
      @(negedge clk);
      if (i == 6) check("ready_after_window", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();

    // Empty window re-armed from DONE.
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    do_start(0);
    wait_done();

    // Three beats of ed 65535: the 17-bit accumulator saturates.
    sb.push_back(mk(3, 3, 196605, 65535, 0, 131071, 1, 3, 2));
    do_start(3);
    for (int i = 0; i < 3; i++) send(8'd0, 8'd0, 16'hFFFF);
    wait_done();

    // New window clears the sticky saturation flag.
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2));
    do_start(1);
    send(8'd1, 8'd1, 16'd1);
    wait_done();

    // Reset after two erroneous beats of a longer window.
    do_start(5);
    send(8'd100, 8'd100, 16'd0);
    send(8'd100, 8'd100, 16'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_over_cnt", over_cnt, 0);
    check("midrst_sum_ed", sum_ed, 0);
    check("midrst_max_ed", max_ed, 0);
    check("midrst_sum_sat", sum_sat, 0);
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("postrst_sum_ed", sum_ed, 0);
    check("postrst_busy", busy, 0);

    // Clean window after the reset: exact 6, reported 7.
    sb.push_back(mk(1, 1, 1, 1, 0, 1, 0, 1, 2));
    do_start(1);
    send(8'd2, 8'd3, 16'd7);
    wait_done();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
